// File: rtl/etapa_if.sv
// etapa_if: MIPS instruction fetch stage (PC, debug-loaded instruction memory, run/step/halt control).
// Define ETAPA_IF_HALT_DETECT_EN to compile in HALT_WORD detection and the HALTED state.
module etapa_if #(
  parameter int               NBITS     = 32,
  parameter int               MEM_DEPTH = 64,
  parameter logic [NBITS-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_Start,
  input  logic                         i_Step_Mode,
  input  logic                         i_Step,
  input  logic                         i_PC_Write,
  input  logic                         i_Branch,
  input  logic [NBITS-1:0]             i_Branch_Target,
  input  logic                         i_Jump,
  input  logic [NBITS-1:0]             i_Jump_Target,
  input  logic                         i_Mem_Wr_En,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_Mem_Wr_Addr,
  input  logic [NBITS-1:0]             i_Mem_Wr_Data,
  output logic [NBITS-1:0]             o_PC,
  output logic [NBITS-1:0]             o_PC4,
  output logic [NBITS-1:0]             o_PC8,
  output logic [NBITS-1:0]             o_Instruction,
  output logic                         o_IF_ID_Flush,
  output logic                         o_Halt
);

  localparam int               AW         = $clog2(MEM_DEPTH);
  localparam logic [NBITS-1:0] WORD_BYTES = NBITS'(32'd4);
  localparam logic [NBITS-1:0] TWO_WORDS  = NBITS'(32'd8);
`ifdef ETAPA_IF_HALT_DETECT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [NBITS-1:0] pc_r, pc_s;
  logic [NBITS-1:0] mem_r [MEM_DEPTH];
  logic             adv_en_s;
  logic             redirect_s;
  logic             halt_hit_s;
  logic [NBITS-1:0] fetch_word_s;

  // Word index drops PC[1:0] and every bit above the memory depth, so fetch wraps.
  assign fetch_word_s = mem_r[pc_r[AW+1:2]];
  assign adv_en_s     = (state_r == ST_RUN) || ((state_r == ST_STEP) && i_Step);
  assign redirect_s   = i_Jump || i_Branch;
  assign halt_hit_s   = HALT_EN && adv_en_s && !redirect_s && (fetch_word_s == HALT_WORD);

  assign o_PC          = pc_r;
  assign o_PC4         = pc_r + WORD_BYTES;
  assign o_PC8         = pc_r + TWO_WORDS;
  assign o_Instruction = adv_en_s ? fetch_word_s : {NBITS{1'b0}};
  assign o_IF_ID_Flush = adv_en_s && redirect_s;
  assign o_Halt        = HALT_EN && (state_r == ST_HALTED);

  // Program-load port: only the debug unit in IDLE may change the program.
  always_ff @(posedge i_clk) begin
    if (i_Mem_Wr_En && (state_r == ST_IDLE)) begin
      mem_r[i_Mem_Wr_Addr] <= i_Mem_Wr_Data;
    end
  end

  // State and PC registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_r <= ST_IDLE;
      pc_r    <= {NBITS{1'b0}};
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
    end
  end

  // Next state and next PC; a redirect beats both a stall and a halt word.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    case (state_r)
      ST_IDLE: begin
        pc_s = {NBITS{1'b0}};
        if (i_Start) begin
          state_s = i_Step_Mode ? ST_STEP : ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN, ST_STEP: begin
        if (!adv_en_s) begin
          pc_s = pc_r;
        end else if (i_Jump) begin
          pc_s = i_Jump_Target;
        end else if (i_Branch) begin
          pc_s = i_Branch_Target;
        end else if (halt_hit_s) begin
          pc_s = pc_r;
        end else if (!i_PC_Write) begin
          pc_s = pc_r;
        end else begin
          pc_s = pc_r + WORD_BYTES;
        end
        if (halt_hit_s) begin
          state_s = ST_HALTED;
        end else begin
          state_s = state_r;
        end
      end
      ST_HALTED: begin
        state_s = HALT_EN ? ST_HALTED : ST_IDLE;
        pc_s    = pc_r;
      end
      default: begin
        state_s = ST_IDLE;
        pc_s    = {NBITS{1'b0}};
      end
    endcase
  end

endmodule

// File: tb/tb_etapa_if.sv
// Self-checking bench for etapa_if: directed vector table, hand sequences, and randomized
// traffic compared against a behavioural model of the fetch stage.
module tb_etapa_if;

  localparam int          NBITS     = 32;
  localparam int          MEM_DEPTH = 64;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
`ifdef ETAPA_IF_HALT_DETECT_EN
  localparam logic HALT_ON = 1'b1;
`else
  localparam logic HALT_ON = 1'b0;
`endif

  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_Start, i_Step_Mode, i_Step, i_PC_Write, i_Branch, i_Jump, i_Mem_Wr_En;
  logic [31:0] i_Branch_Target, i_Jump_Target, i_Mem_Wr_Data;
  logic [5:0]  i_Mem_Wr_Addr;
  logic [31:0] o_PC, o_PC4, o_PC8, o_Instruction;
  logic        o_IF_ID_Flush, o_Halt;

  always #5 i_clk = ~i_clk;

  etapa_if #(.NBITS(NBITS), .MEM_DEPTH(MEM_DEPTH), .HALT_WORD(HALT_WORD)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_Start(i_Start), .i_Step_Mode(i_Step_Mode),
    .i_Step(i_Step), .i_PC_Write(i_PC_Write), .i_Branch(i_Branch),
    .i_Branch_Target(i_Branch_Target), .i_Jump(i_Jump), .i_Jump_Target(i_Jump_Target),
    .i_Mem_Wr_En(i_Mem_Wr_En), .i_Mem_Wr_Addr(i_Mem_Wr_Addr), .i_Mem_Wr_Data(i_Mem_Wr_Data),
    .o_PC(o_PC), .o_PC4(o_PC4), .o_PC8(o_PC8), .o_Instruction(o_Instruction),
    .o_IF_ID_Flush(o_IF_ID_Flush), .o_Halt(o_Halt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [31:0] m_mem [MEM_DEPTH];
  logic [31:0] m_pc;
  int          m_mode;

  typedef struct {
    logic        start, mode, pcw, br, jmp;
    logic [31:0] bt, jt, e_pc, e_ins;
    logic        e_fl;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic start, input logic pcw, input logic br, input logic [31:0] bt,
                              input logic jmp, input logic [31:0] jt, input logic [31:0] e_pc,
                              input logic [31:0] e_ins, input logic e_fl);
    vec_t v;
    v.start = start; v.mode = 1'b0; v.pcw = pcw; v.br = br; v.bt = bt; v.jmp = jmp; v.jt = jt;
    v.e_pc = e_pc; v.e_ins = e_ins; v.e_fl = e_fl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Let combinational outputs settle, then compare every output.
  task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic fl, input logic hl);
    #1;
    chk({tag, ".pc"},    o_PC, pc);
    chk({tag, ".pc4"},   o_PC4, pc + 32'd4);
    chk({tag, ".pc8"},   o_PC8, pc + 32'd8);
    chk({tag, ".instr"}, o_Instruction, ins);
    chk({tag, ".flush"}, 32'(o_IF_ID_Flush), 32'(fl));
    chk({tag, ".halt"},  32'(o_Halt), 32'(hl));
  endtask

  task automatic idle_inputs();
    i_Start = 1'b0; i_Step_Mode = 1'b0; i_Step = 1'b0; i_PC_Write = 1'b1;
    i_Branch = 1'b0; i_Jump = 1'b0; i_Branch_Target = 32'd0; i_Jump_Target = 32'd0;
    i_Mem_Wr_En = 1'b0; i_Mem_Wr_Addr = 6'd0; i_Mem_Wr_Data = 32'd0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    logic [5:0] a6;
    a6 = a[5:0];
    i_Mem_Wr_En = 1'b1; i_Mem_Wr_Addr = a6; i_Mem_Wr_Data = d;
    m_mem[a6] = d;
    tick();
    i_Mem_Wr_En = 1'b0;
  endtask

  // Mid-cycle reset pulse: outputs must return to reset values with no clock edge.
  task automatic reset_pulse(input string tag);
    idle_inputs();
    #1;
    i_reset = 1'b0;
    chk_out(tag, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    i_reset = 1'b1;
    m_mode = M_IDLE;
    m_pc   = 32'd0;
    tick();
  endtask

  function automatic logic [31:0] m_word(input logic [31:0] pc);
    return m_mem[(pc / 32'd4) % MEM_DEPTH];
  endfunction

  function automatic logic m_fetching();
    return (m_mode == M_RUN) || ((m_mode == M_STEP) && i_Step);
  endfunction

  // Compare against the model for this cycle, clock, then advance the model.
  task automatic model_cycle(input string tag);
    logic [31:0] exp_ins, n_pc;
    int          n_mode;
    logic        f;
    f       = m_fetching();
    exp_ins = f ? m_word(m_pc) : 32'd0;
    chk_out(tag, m_pc, exp_ins, f && (i_Branch || i_Jump), HALT_ON && (m_mode == M_HALT));
    n_pc = m_pc;
    n_mode = m_mode;
    if (m_mode == M_IDLE) begin
      n_pc = 32'd0;
      if (i_Start) n_mode = i_Step_Mode ? M_STEP : M_RUN;
    end else if (f) begin
      if (i_Jump) n_pc = i_Jump_Target;
      else if (i_Branch) n_pc = i_Branch_Target;
      else if (HALT_ON && exp_ins == HALT_WORD) n_mode = M_HALT;
      else if (i_PC_Write) n_pc = m_pc + 32'd4;
    end
    if (m_mode == M_IDLE && i_Mem_Wr_En) m_mem[i_Mem_Wr_Addr] = i_Mem_Wr_Data;
    @(posedge i_clk);
    m_pc = n_pc;
    m_mode = n_mode;
    #1;
  endtask

  initial begin
    idle_inputs();
    m_mode = M_IDLE;
    m_pc   = 32'd0;
    repeat (2) @(posedge i_clk);
    #1;
    chk_out("reset", 32'd0, 32'd0, 1'b0, 1'b0);
    i_reset = 1'b1;
    tick();

    // Program load in IDLE
    for (int i = 0; i < MEM_DEPTH; i++) wr(i, 32'hA500_0000 | 32'(i));
    wr(0, 32'h2001_0005);
    wr(1, 32'h2002_0003);
    wr(2, 32'h0022_1820);

    // Directed run: stall, branch under stall, jump over branch, wrap of the index.
    tbl[0]  = mk(1, 1, 0, 32'h0,  0, 32'h0,  32'h000, 32'h0000_0000, 0);
    tbl[1]  = mk(0, 1, 0, 32'h0,  0, 32'h0,  32'h000, 32'h2001_0005, 0);
    tbl[2]  = mk(0, 1, 0, 32'h0,  0, 32'h0,  32'h004, 32'h2002_0003, 0);
    tbl[3]  = mk(0, 0, 0, 32'h0,  0, 32'h0,  32'h008, 32'h0022_1820, 0);
    tbl[4]  = mk(0, 0, 0, 32'h0,  0, 32'h0,  32'h008, 32'h0022_1820, 0);
    tbl[5]  = mk(0, 1, 0, 32'h0,  0, 32'h0,  32'h008, 32'h0022_1820, 0);
    tbl[6]  = mk(0, 1, 0, 32'h0,  0, 32'h0,  32'h00C, 32'hA500_0003, 0);
    tbl[7]  = mk(0, 0, 1, 32'h40, 0, 32'h0,  32'h010, 32'hA500_0004, 1);
    tbl[8]  = mk(0, 1, 1, 32'h20, 1, 32'h80, 32'h040, 32'hA500_0010, 1);
    tbl[9]  = mk(0, 1, 0, 32'h0,  0, 32'h0,  32'h080, 32'hA500_0020, 0);
    tbl[10] = mk(0, 0, 0, 32'h0,  1, 32'hFC, 32'h084, 32'hA500_0021, 1);
    tbl[11] = mk(0, 1, 0, 32'h0,  0, 32'h0,  32'h0FC, 32'hA500_003F, 0);
    tbl[12] = mk(0, 1, 0, 32'h0,  0, 32'h0,  32'h100, 32'h2001_0005, 0);
    tbl[13] = mk(0, 1, 0, 32'h0,  0, 32'h0,  32'h104, 32'h2002_0003, 0);
    tbl[14] = mk(0, 1, 0, 32'h0,  1, 32'h1C, 32'h108, 32'h0022_1820, 1);
    tbl[15] = mk(0, 0, 0, 32'h0,  0, 32'h0,  32'h01C, 32'hA500_0007, 0);
    for (int r = 0; r < 16; r++) begin
      i_Start = tbl[r].start; i_Step_Mode = tbl[r].mode; i_PC_Write = tbl[r].pcw;
      i_Branch = tbl[r].br; i_Branch_Target = tbl[r].bt;
      i_Jump = tbl[r].jmp; i_Jump_Target = tbl[r].jt;
      chk_out($sformatf("row%0d", r), tbl[r].e_pc, tbl[r].e_ins, tbl[r].e_fl, 1'b0);
      tick();
    end

    // Asynchronous reset from RUN at PC 0x1C, then IDLE holds PC 0.
    reset_pulse("async_reset");
    chk_out("idle0", 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    chk_out("idle1", 32'd0, 32'd0, 1'b0, 1'b0);

    // Single-step mode
    i_Start = 1'b1; i_Step_Mode = 1'b1;
    chk_out("step_start", 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      chk_out($sformatf("step_wait%0d", k), 32'd0, 32'd0, 1'b0, 1'b0);
      tick();
    end
    i_Step = 1'b1;
    chk_out("step_pulse", 32'd0, 32'h2001_0005, 1'b0, 1'b0);
    tick();
    i_Step = 1'b0;
    chk_out("step_after0", 32'd4, 32'd0, 1'b0, 1'b0);
    tick();
    chk_out("step_after1", 32'd4, 32'd0, 1'b0, 1'b0);
    tick();

    // Halt word at mem[3], first masked by a redirect, then taking effect.
    reset_pulse("reset_halt");
    wr(3, HALT_WORD);
    i_Start = 1'b1;
    tick();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      chk_out($sformatf("h_run%0d", k), 32'(4 * k), m_mem[k], 1'b0, 1'b0);
      tick();
    end
    i_Jump = 1'b1; i_Jump_Target = 32'h0C;
    chk_out("h_redirect", 32'h0C, HALT_WORD, 1'b1, 1'b0);
    tick();
    idle_inputs();
    i_Mem_Wr_En = 1'b1; i_Mem_Wr_Addr = 6'd5; i_Mem_Wr_Data = 32'hDEAD_BEEF;
    chk_out("h_fetch", 32'h0C, HALT_WORD, 1'b0, 1'b0);
    tick();
    i_Branch = 1'b1; i_Branch_Target = 32'h40;
    chk_out("h_cycle1", HALT_ON ? 32'h0C : 32'h10, HALT_ON ? 32'd0 : 32'hA500_0004,
            !HALT_ON, HALT_ON);
    tick();
    idle_inputs();
    chk_out("h_cycle2", HALT_ON ? 32'h0C : 32'h40, HALT_ON ? 32'd0 : 32'hA500_0010,
            1'b0, HALT_ON);
    tick();
    reset_pulse("reset_after_halt");
    i_Start = 1'b1;
    tick();
    idle_inputs();
    i_Jump = 1'b1; i_Jump_Target = 32'h14;
    chk_out("wr_ignored_j", 32'd0, 32'h2001_0005, 1'b1, 1'b0);
    tick();
    idle_inputs();
    chk_out("wr_ignored", 32'h14, 32'hA500_0005, 1'b0, 1'b0);
    tick();

    // Randomized traffic against the model
    reset_pulse("reset_rand");
    for (int i = 0; i < MEM_DEPTH; i++) begin
      logic [31:0] d;
      d = $urandom();
      if ($urandom_range(15) == 0) d = HALT_WORD;
      wr(i, d);
    end
    for (int n = 0; n < 400; n++) begin
      i_Start     = ($urandom_range(3) == 0);
      i_Step_Mode = 1'($urandom_range(1));
      i_Step      = 1'($urandom_range(1));
      i_PC_Write  = ($urandom_range(3) != 0);
      i_Branch    = ($urandom_range(7) == 0);
      i_Jump      = ($urandom_range(7) == 0);
      i_Branch_Target = $urandom();
      i_Jump_Target   = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : $urandom();
      i_Mem_Wr_En   = ($urandom_range(3) == 0);
      i_Mem_Wr_Addr = 6'($urandom_range(63));
      i_Mem_Wr_Data = $urandom();
      model_cycle($sformatf("rand%0d", n));
      if (m_mode == M_HALT || (n % 50) == 49) reset_pulse($sformatf("rand_reset%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
